// File: rtl/lcd_pkg.sv
// Shared HD44780 definitions for the LCD read/write custom instructions:
// FSM encoding, register bit positions and default bus timing at 50 MHz.
package lcd_pkg;

  typedef logic [2:0] lcd_state_t;

  localparam lcd_state_t ST_IDLE    = 3'd0;
  localparam lcd_state_t ST_SETUP   = 3'd1;
  localparam lcd_state_t ST_EN_HIGH = 3'd2;
  localparam lcd_state_t ST_EN_LOW  = 3'd3;
  localparam lcd_state_t ST_DONE    = 3'd4;

  localparam int BF_BIT      = 7;
  localparam int BYTE_LSB    = 0;
  localparam int TIMEOUT_BIT = 8;

  localparam int LCD_SETUP_CYCLES   = 2;
  localparam int LCD_EN_HIGH_CYCLES = 25;
  localparam int LCD_EN_LOW_CYCLES  = 25;
  localparam int LCD_MAX_POLLS      = 4096;

  // Bits needed to hold the values 0 .. n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lcd_strobe_timer.sv
// Down-counter for LCD bus phases: loaded with N-1 on phase entry, expired
// is high during the N-th cycle of the phase.
module lcd_strobe_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clk_en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clk_en) begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read-cycle custom instruction (status or data RAM), with optional
// busy-flag polling; LCD_POLL_TIMEOUT_EN bounds polling to MAX_POLLS re-reads.
module lcd_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES   = LCD_SETUP_CYCLES,
  parameter int EN_HIGH_CYCLES = LCD_EN_HIGH_CYCLES,
  parameter int EN_LOW_CYCLES  = LCD_EN_LOW_CYCLES,
  parameter int MAX_POLLS      = LCD_MAX_POLLS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        done,
  output logic        rs,
  output logic        rw,
  output logic        en,
  input  logic [7:0]  db_in,
  output logic [2:0]  dbg_state
);

  localparam int MAX_T = (SETUP_CYCLES > EN_HIGH_CYCLES) ?
                         ((SETUP_CYCLES > EN_LOW_CYCLES) ? SETUP_CYCLES : EN_LOW_CYCLES) :
                         ((EN_HIGH_CYCLES > EN_LOW_CYCLES) ? EN_HIGH_CYCLES : EN_LOW_CYCLES);
  localparam int CNT_W = cnt_width(MAX_T);
  localparam logic [CNT_W-1:0] SETUP_LOAD   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_HIGH_LOAD = CNT_W'(EN_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] EN_LOW_LOAD  = CNT_W'(EN_LOW_CYCLES - 1);

  // Handshake: start is accepted only in IDLE on a clk_en cycle; done is a
  // single clk_en-qualified cycle with result valid; no back-pressure exists.
  lcd_state_t state_q, state_d;
  logic       rs_q, rs_d, poll_q, poll_d, rw_q, rw_d, en_q, en_d;
  logic [7:0] byte_q, byte_d;
  logic [31:0] result_q, result_d;
  logic       tmr_load, tmr_expired;
  logic [CNT_W-1:0] tmr_val;
  logic       poll_clr, poll_inc, poll_limit;

  lcd_strobe_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clk_en   (clk_en),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    poll_d   = poll_q;
    rw_d     = rw_q;
    en_d     = en_q;
    byte_d   = byte_q;
    result_d = result_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    poll_clr = 1'b0;
    poll_inc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rs_d     = dataa[0];
          poll_d   = dataa[1] & ~dataa[0];
          rw_d     = 1'b1;
          en_d     = 1'b0;
          poll_clr = 1'b1;
          state_d  = ST_SETUP;
          tmr_load = 1'b1;
          tmr_val  = SETUP_LOAD;
        end
      end
      ST_SETUP: begin
        if (tmr_expired) begin
          en_d     = 1'b1;
          state_d  = ST_EN_HIGH;
          tmr_load = 1'b1;
          tmr_val  = EN_HIGH_LOAD;
        end
      end
      ST_EN_HIGH: begin
        // db is sampled on the same edge that drops en, inside tDDR/tH.
        if (tmr_expired) begin
          en_d     = 1'b0;
          byte_d   = db_in;
          state_d  = ST_EN_LOW;
          tmr_load = 1'b1;
          tmr_val  = EN_LOW_LOAD;
        end
      end
      ST_EN_LOW: begin
        if (tmr_expired) begin
          tmr_load = 1'b1;
          if (poll_q && byte_q[BF_BIT] && !poll_limit) begin
            poll_inc = 1'b1;
            state_d  = ST_SETUP;
            tmr_val  = SETUP_LOAD;
          end else begin
            rw_d     = 1'b0;
            state_d  = ST_DONE;
            result_d = '0;
            result_d[BYTE_LSB +: 8]  = byte_q;
            result_d[TIMEOUT_BIT]    = poll_q & byte_q[BF_BIT] & poll_limit;
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        tmr_load = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        rw_d    = 1'b0;
        en_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rs_q     <= 1'b0;
      poll_q   <= 1'b0;
      rw_q     <= 1'b0;
      en_q     <= 1'b0;
      byte_q   <= '0;
      result_q <= '0;
    end else if (clk_en) begin
      state_q  <= state_d;
      rs_q     <= rs_d;
      poll_q   <= poll_d;
      rw_q     <= rw_d;
      en_q     <= en_d;
      byte_q   <= byte_d;
      result_q <= result_d;
    end
  end

`ifdef LCD_POLL_TIMEOUT_EN
  localparam int PC_W = cnt_width(MAX_POLLS + 1);
  logic [PC_W-1:0] poll_cnt_q, poll_cnt_d;

  always_comb begin
    poll_cnt_d = poll_cnt_q;
    if (poll_clr) begin
      poll_cnt_d = '0;
    end else if (poll_inc) begin
      poll_cnt_d = poll_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt_q <= '0;
    end else if (clk_en) begin
      poll_cnt_q <= poll_cnt_d;
    end
  end

  assign poll_limit = (poll_cnt_q == PC_W'(MAX_POLLS));
`else
  logic unused_poll;
  assign poll_limit  = 1'b0;
  assign unused_poll = poll_clr ^ poll_inc ^ (^MAX_POLLS);
`endif

  logic unused_inputs;
  assign unused_inputs = ^{datab, dataa[31:2]};

  assign result    = result_q;
  assign done      = (state_q == ST_DONE);
  assign rs        = rs_q;
  assign rw        = rw_q;
  assign en        = en_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lcd_reader.sv
// Directed bench for lcd_reader: vector table of single reads plus polling,
// clk_en freeze and reset corner cases; timeout case needs LCD_POLL_TIMEOUT_EN.
module tb_lcd_reader;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset, clk_en, start;
  logic [31:0] dataa, datab;
  logic [31:0] result;
  logic        done, rs, rw, en;
  logic [7:0]  db_in;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  db;
    logic [31:0] exp_res;
    int          exp_lat;
    int          exp_en;
  } vec_t;

  vec_t vecs[6];

  lcd_reader #(.MAX_POLLS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .clk_en    (clk_en),
    .start     (start),
    .dataa     (dataa),
    .datab     (datab),
    .result    (result),
    .done      (done),
    .rs        (rs),
    .rw        (rw),
    .en        (en),
    .db_in     (db_in),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one read and follows it to done. frz >= 0 freezes clk_en for 10
  // cycles from that sample on and injects start pulses while busy.
  task automatic run_txn(input logic [31:0] a, input logic [7:0] d0, input logic [7:0] d1,
                         input int sw, input int frz,
                         output int lat, output int en_cyc, output int pulses,
                         output int rw_bad, output int rs_bad);
    logic en_prev;
    db_in = d0;
    dataa = a;
    start = 1'b1;
    tick();
    start   = 1'b0;
    dataa   = '0;
    lat     = 0;
    en_cyc  = 0;
    pulses  = 0;
    rw_bad  = 0;
    rs_bad  = 0;
    en_prev = 1'b0;
    while (done !== 1'b1 && lat < 2000) begin
      tick();
      lat++;
      if (rs !== a[0]) rs_bad++;
      if (done !== 1'b1) begin
        if (rw !== 1'b1) rw_bad++;
        if (en === 1'b1) en_cyc++;
        if (en_prev && en !== 1'b1) begin
          pulses++;
          if (pulses == sw) db_in = d1;
        end
        en_prev = (en === 1'b1);
      end
      if (frz >= 0) begin
        if (lat == frz) begin
          clk_en = 1'b0;
          start  = 1'b1;
          dataa  = {31'b0, ~a[0]};
        end
        if (lat == frz + 10) begin
          clk_en = 1'b1;
          start  = 1'b0;
        end
        if (lat == frz + 20) start = 1'b1;
        if (lat == frz + 21) start = 1'b0;
      end
    end
    start  = 1'b0;
    clk_en = 1'b1;
    check("done_within_bound", {31'b0, done}, 32'd1);
  endtask

  // start during the DONE cycle must be ignored; result must hold afterwards.
  task automatic tail(input string name, input logic [31:0] exp_res);
    start = 1'b1;
    dataa = 32'd1;
    tick();
    start = 1'b0;
    dataa = '0;
    check({name, "_done_drop"}, {31'b0, done}, 32'd0);
    check({name, "_idle_after"}, {29'b0, dbg_state}, {29'b0, ST_IDLE});
    check({name, "_rw_after"}, {31'b0, rw}, 32'd0);
    check({name, "_result_hold"}, result, exp_res);
  endtask

  initial begin
    int lat, en_cyc, pulses, rw_bad, rs_bad;

    vecs[0] = '{a: 32'h0000_0001, db: 8'h41, exp_res: 32'h41, exp_lat: 52, exp_en: 25};
    vecs[1] = '{a: 32'h0000_0000, db: 8'h8A, exp_res: 32'h8A, exp_lat: 52, exp_en: 25};
    vecs[2] = '{a: 32'h0000_0003, db: 8'hC3, exp_res: 32'hC3, exp_lat: 52, exp_en: 25};
    vecs[3] = '{a: 32'hFFFF_FFF0, db: 8'h00, exp_res: 32'h00, exp_lat: 52, exp_en: 25};
    vecs[4] = '{a: 32'h0000_0002, db: 8'h7F, exp_res: 32'h7F, exp_lat: 52, exp_en: 25};
    vecs[5] = '{a: 32'h0000_0005, db: 8'hFF, exp_res: 32'hFF, exp_lat: 52, exp_en: 25};

    // clock/reset
    reset  = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = '0;
    datab  = 32'hDEAD_BEEF;
    db_in  = 8'h00;
    repeat (3) tick();
    check("rst_result", result, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_rs", {31'b0, rs}, 32'd0);
    check("rst_rw", {31'b0, rw}, 32'd0);
    check("rst_en", {31'b0, en}, 32'd0);
    check("rst_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].a, vecs[i].db, vecs[i].db, 0, -1, lat, en_cyc, pulses, rw_bad, rs_bad);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_en_cycles", i), en_cyc, vecs[i].exp_en);
      check($sformatf("v%0d_pulses", i), pulses, 1);
      check($sformatf("v%0d_rw_busy", i), rw_bad, 0);
      check($sformatf("v%0d_rs", i), rs_bad, 0);
      check($sformatf("v%0d_result", i), result, vecs[i].exp_res);
      check($sformatf("v%0d_rw_done", i), {31'b0, rw}, 32'd0);
      tail($sformatf("v%0d", i), vecs[i].exp_res);
    end

    // busy poll: three BF=1 reads, then BF=0
    run_txn(32'd2, 8'h80, 8'h05, 3, -1, lat, en_cyc, pulses, rw_bad, rs_bad);
    check("poll_latency", lat, 208);
    check("poll_pulses", pulses, 4);
    check("poll_en_cycles", en_cyc, 100);
    check("poll_rw_busy", rw_bad, 0);
    check("poll_result", result, 32'h05);
    tail("poll", 32'h05);

`ifdef LCD_POLL_TIMEOUT_EN
    run_txn(32'd2, 8'hFF, 8'hFF, 0, -1, lat, en_cyc, pulses, rw_bad, rs_bad);
    check("tmo_latency", lat, 260);
    check("tmo_pulses", pulses, 5);
    check("tmo_result", result, 32'h1FF);
    tail("tmo", 32'h1FF);
`endif

    // clk_en frozen for 10 cycles inside EN_HIGH, plus starts while busy
    run_txn(32'd1, 8'h5A, 8'h5A, 0, 10, lat, en_cyc, pulses, rw_bad, rs_bad);
    check("frz_latency", lat, 62);
    check("frz_en_cycles", en_cyc, 35);
    check("frz_pulses", pulses, 1);
    check("frz_rs", rs_bad, 0);
    check("frz_rw_busy", rw_bad, 0);
    check("frz_result", result, 32'h5A);
    clk_en = 1'b0;
    start  = 1'b1;
    dataa  = 32'd1;
    repeat (3) tick();
    check("frz_done_held", {31'b0, done}, 32'd1);
    check("frz_state_held", {29'b0, dbg_state}, {29'b0, ST_DONE});
    clk_en = 1'b1;
    start  = 1'b0;
    dataa  = '0;
    tick();
    check("frz_done_drop", {31'b0, done}, 32'd0);
    check("frz_idle_after", {29'b0, dbg_state}, {29'b0, ST_IDLE});

    // reset in the middle of EN_HIGH
    dataa = 32'd1;
    db_in = 8'h11;
    start = 1'b1;
    tick();
    start = 1'b0;
    dataa = '0;
    repeat (10) tick();
    check("mid_en_high", {31'b0, en}, 32'd1);
    reset = 1'b1;
    tick();
    check("mrst_en", {31'b0, en}, 32'd0);
    check("mrst_rw", {31'b0, rw}, 32'd0);
    check("mrst_done", {31'b0, done}, 32'd0);
    check("mrst_result", result, 32'd0);
    check("mrst_state", {29'b0, dbg_state}, {29'b0, ST_IDLE});
    reset = 1'b0;
    tick();
    run_txn(32'd0, 8'h3C, 8'h3C, 0, -1, lat, en_cyc, pulses, rw_bad, rs_bad);
    check("post_rst_latency", lat, 52);
    check("post_rst_result", result, 32'h3C);
    tail("post_rst", 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
